// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch arbiter.
package inst_fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fetch_state_e;

  // Width of a counter that can hold 0..mem_lat.
  function automatic int unsigned lat_cnt_w(input int unsigned mem_lat);
    return $clog2(mem_lat + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority pick over the request vector; pointer advances past the winner on adv_i.
module rr_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  localparam int unsigned IDX_W = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] req_i,
  input  logic                 adv_i,
  output logic [IDX_W-1:0]     winner_c_o,
  output logic                 any_req_c_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // First requester at or after the pointer, wrapping modulo NUM_CORES.
  always_comb begin
    winner_c_o  = '0;
    any_req_c_o = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!any_req_c_o && req_i[idx[IDX_W-1:0]]) begin
        any_req_c_o = 1'b1;
        winner_c_o  = idx[IDX_W-1:0];
      end
    end
  end

  assign ptr_d = (32'(winner_c_o) == NUM_CORES - 1) ? '0 : winner_c_o + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr_q <= '0;
    else if (adv_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/inst_fetch_arbiter.sv
// Shares one single-port instruction memory between NUM_CORES fetch units,
// one fetch at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
module inst_fetch_arbiter
  import inst_fetch_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_CORES);
  localparam int unsigned CNT_W = lat_cnt_w(MEM_LAT);

  fetch_state_e         state_q, state_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [IDX_W-1:0]     winner_c;
  logic                 any_req_c;
  logic                 adv_c;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .adv_i       (adv_c),
    .winner_c_o  (winner_c),
    .any_req_c_o (any_req_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    adv_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d    = ISSUE;
          win_d      = winner_c;
          gnt_d      = NUM_CORES'(1) << winner_c;
          mem_en_d   = 1'b1;
          mem_addr_d = req_addr[32'(winner_c) * ADDR_W +: ADDR_W];
          adv_c      = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // Memory data is valid during the last WAIT cycle.
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          state_d  = RESP;
          rdata_d  = mem_rdata;
          rvalid_d = NUM_CORES'(1) << win_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Directed bench: transaction table on a MEM_LAT=1 instance plus corner-case
// sequences (late address change, winner drop, mid-WAIT reset, MEM_LAT=3 instance).
module tb_inst_fetch_arbiter;

  logic        clk;
  logic        rst;

  logic [3:0]  req1, gnt1, rv1;
  logic [43:0] addr1;
  logic [31:0] rdata1, mrd1, mp1;
  logic        en1;
  logic [10:0] maddr1;

  logic [3:0]  req3, gnt3, rv3;
  logic [43:0] addr3;
  logic [31:0] rdata3, mrd3, s3_0, s3_1, s3_2;
  logic        en3;
  logic [10:0] maddr3;

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch_arbiter #(.NUM_CORES(4), .ADDR_W(11), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_addr(addr1), .gnt(gnt1), .rvalid(rv1),
    .rdata(rdata1), .mem_en(en1), .mem_addr(maddr1), .mem_rdata(mrd1));

  inst_fetch_arbiter #(.NUM_CORES(4), .ADDR_W(11), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_addr(addr3), .gnt(gnt3), .rvalid(rv3),
    .rdata(rdata3), .mem_en(en3), .mem_addr(maddr3), .mem_rdata(mrd3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [10:0] a);
    return {5'h1a, a, 5'h05, ~a};
  endfunction

  // Memory models: data appears MEM_LAT cycles after the issue edge; junk otherwise.
  always @(posedge clk) mp1 <= en1 ? word_of(maddr1) : 32'hDEAD_BEEF;
  assign mrd1 = mp1;

  always @(posedge clk) begin
    s3_0 <= en3 ? word_of(maddr3) : 32'hDEAD_BEEF;
    s3_1 <= s3_0;
    s3_2 <= s3_1;
  end
  assign mrd3 = s3_2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full fetch on dut1, starting from an IDLE cycle.
  task automatic run_txn1(input int w, input logic [10:0] a);
    logic [3:0] oh;
    oh = 4'(1) << w;
    tick();
    chk("issue_gnt", 64'(gnt1), 64'(oh));
    chk("issue_en", 64'(en1), 64'd1);
    chk("issue_addr", 64'(maddr1), 64'(a));
    chk("issue_rv", 64'(rv1), 64'd0);
    tick();
    chk("wait_en", 64'(en1), 64'd0);
    chk("wait_rv", 64'(rv1), 64'd0);
    chk("wait_gnt", 64'(gnt1), 64'(oh));
    tick();
    chk("resp_rv", 64'(rv1), 64'(oh));
    chk("resp_rdata", 64'(rdata1), 64'(word_of(a)));
    chk("resp_gnt", 64'(gnt1), 64'(oh));
    req1[w] = 1'b0;
    tick();
    chk("idle_rv", 64'(rv1), 64'd0);
    chk("idle_gnt", 64'(gnt1), 64'd0);
    chk("idle_rdata", 64'(rdata1), 64'(word_of(a)));
  endtask

  typedef struct {
    bit         rst_first;
    logic [3:0] add_req;
    logic [10:0] a0, a1, a2, a3;
    int         exp_w;
    logic [10:0] exp_a;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{1'b0, 4'b0001, 11'h00b, 11'h000, 11'h000, 11'h000, 0, 11'h00b};
    vt[1]  = '{1'b1, 4'b1111, 11'h100, 11'h101, 11'h102, 11'h103, 0, 11'h100};
    vt[2]  = '{1'b0, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 1, 11'h101};
    vt[3]  = '{1'b0, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 2, 11'h102};
    vt[4]  = '{1'b0, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 3, 11'h103};
    vt[5]  = '{1'b0, 4'b1001, 11'h200, 11'h000, 11'h000, 11'h203, 0, 11'h200};
    vt[6]  = '{1'b0, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 3, 11'h203};
    vt[7]  = '{1'b0, 4'b0110, 11'h000, 11'h311, 11'h322, 11'h000, 1, 11'h311};
    vt[8]  = '{1'b0, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 2, 11'h322};
    vt[9]  = '{1'b0, 4'b0011, 11'h40a, 11'h41b, 11'h000, 11'h000, 0, 11'h40a};
    vt[10] = '{1'b0, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 1, 11'h41b};

    rst = 1'b1;
    req1 = '0; addr1 = '0; req3 = '0; addr3 = '0;
    tick();
    tick();
    chk("rst_gnt1", 64'(gnt1), 64'd0);
    chk("rst_rv1", 64'(rv1), 64'd0);
    chk("rst_en1", 64'(en1), 64'd0);
    chk("rst_rdata1", 64'(rdata1), 64'd0);
    chk("rst_maddr3", 64'(maddr3), 64'd0);
    chk("rst_gnt3", 64'(gnt3), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vt[i].rst_first) do_reset();
      if (vt[i].add_req[0]) begin req1[0] = 1'b1; addr1[0*11 +: 11] = vt[i].a0; end
      if (vt[i].add_req[1]) begin req1[1] = 1'b1; addr1[1*11 +: 11] = vt[i].a1; end
      if (vt[i].add_req[2]) begin req1[2] = 1'b1; addr1[2*11 +: 11] = vt[i].a2; end
      if (vt[i].add_req[3]) begin req1[3] = 1'b1; addr1[3*11 +: 11] = vt[i].a3; end
      run_txn1(vt[i].exp_w, vt[i].exp_a);
    end

    // Address changed after the grant edge must be ignored (pointer at 2).
    req1[2] = 1'b1; addr1[2*11 +: 11] = 11'h010;
    tick();
    chk("chg_gnt", 64'(gnt1), 64'h4);
    chk("chg_maddr", 64'(maddr1), 64'h010);
    addr1[2*11 +: 11] = 11'h7ff;
    tick();
    chk("chg_wait_maddr", 64'(maddr1), 64'h010);
    tick();
    chk("chg_rv", 64'(rv1), 64'h4);
    chk("chg_rdata", 64'(rdata1), 64'(word_of(11'h010)));
    req1[2] = 1'b0;
    tick();

    // Winner drops req mid-transaction; the fetch still completes (pointer at 3).
    req1[1] = 1'b1; addr1[1*11 +: 11] = 11'h0aa;
    tick();
    chk("drop_gnt", 64'(gnt1), 64'h2);
    req1[1] = 1'b0;
    tick();
    tick();
    chk("drop_rv", 64'(rv1), 64'h2);
    chk("drop_rdata", 64'(rdata1), 64'(word_of(11'h0aa)));
    tick();
    chk("drop_idle_gnt", 64'(gnt1), 64'd0);

    // Reset asserted during WAIT clears outputs at once and drops the fetch.
    req1[2] = 1'b1; addr1[2*11 +: 11] = 11'h055;
    tick();
    chk("mr_issue_gnt", 64'(gnt1), 64'h4);
    tick();
    chk("mr_wait_en", 64'(en1), 64'd0);
    rst = 1'b1;
    #1;
    chk("mr_gnt", 64'(gnt1), 64'd0);
    chk("mr_maddr", 64'(maddr1), 64'd0);
    chk("mr_rdata", 64'(rdata1), 64'd0);
    chk("mr_rv", 64'(rv1), 64'd0);
    tick();
    chk("mr_rv_hold", 64'(rv1), 64'd0);
    tick();
    rst = 1'b0;
    chk("mr_rel_rv", 64'(rv1), 64'd0);
    run_txn1(2, 11'h055);

    // MEM_LAT=3 instance: rvalid four cycles after issue, single mem_en cycle.
    req3[1] = 1'b1; addr3[1*11 +: 11] = 11'h0c3;
    tick();
    chk("l3_en", 64'(en3), 64'd1);
    chk("l3_maddr", 64'(maddr3), 64'h0c3);
    chk("l3_gnt", 64'(gnt3), 64'h2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("l3_wait_en", 64'(en3), 64'd0);
      chk("l3_wait_rv", 64'(rv3), 64'd0);
    end
    tick();
    chk("l3_rv", 64'(rv3), 64'h2);
    chk("l3_rdata", 64'(rdata3), 64'(word_of(11'h0c3)));
    req3[1] = 1'b0;
    tick();
    chk("l3_idle_rv", 64'(rv3), 64'd0);
    chk("l3_idle_gnt", 64'(gnt3), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
